// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct values, control-signal bundle and a
// helper that recognises the supported R-type functions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic reg_read;
        logic reg_write;
        logic reg_dst;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    function automatic logic r_funct_known(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_JR,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: r_funct_known = 1'b1;
            default:         r_funct_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational MIPS ALU: selects the operation from opcode/funct and
// yields zero for anything it does not recognise.
module mips_alu
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] immediate,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic [31:0] result
);

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign imm_sext = {{16{immediate[15]}}, immediate};
    assign imm_zext = {16'h0000, immediate};

    always_comb begin
        result = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: result = rs_content + rt_content;
                    FN_SUB, FN_SUBU: result = rs_content - rt_content;
                    FN_AND:  result = rs_content & rt_content;
                    FN_OR:   result = rs_content | rt_content;
                    FN_XOR:  result = rs_content ^ rt_content;
                    FN_NOR:  result = ~(rs_content | rt_content);
                    FN_SLT:  result = {31'b0, $signed(rs_content) < $signed(rt_content)};
                    FN_SLTU: result = {31'b0, rs_content < rt_content};
                    FN_SLL:  result = rt_content << shamt;
                    FN_SRL:  result = rt_content >> shamt;
                    FN_SRA:  result = $unsigned($signed(rt_content) >>> shamt);
                    default: result = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result = rs_content + imm_sext;
            OP_SLTI:  result = {31'b0, $signed(rs_content) < $signed(imm_sext)};
            OP_SLTIU: result = {31'b0, rs_content < imm_sext};
            OP_ANDI:  result = rs_content & imm_zext;
            OP_ORI:   result = rs_content | imm_zext;
            OP_XORI:  result = rs_content ^ imm_zext;
            OP_LUI:   result = {immediate, 16'h0000};
            OP_BEQ:   result = rs_content - rt_content;
            // bne inverts the sense so that a zero result always means "take it"
            OP_BNE:   result = (rs_content != rt_content) ? 32'd0 : 32'd1;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode/execute: instruction field split, control
// generation, ALU and the word-indexed program counter.
module mips_decode_execute
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic [31:0] pc,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] address,
    output logic        reg_read,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic [31:0] alu_result,
    output logic        branch_taken
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    ctrl_t       ctrl;
    logic        is_jr;

    assign opcode    = instruction[31:26];
    assign rs        = instruction[25:21];
    assign rt        = instruction[20:16];
    assign rd        = instruction[15:11];
    assign shamt     = instruction[10:6];
    assign funct     = instruction[5:0];
    assign immediate = instruction[15:0];
    assign address   = instruction[25:0];

    assign is_jr = (opcode == OP_RTYPE) && (funct == FN_JR);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                if (is_jr) begin
                    ctrl.reg_read = 1'b1;
                end else if (r_funct_known(funct)) begin
                    ctrl.reg_read  = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.reg_read  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                ctrl.reg_read  = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.reg_read = 1'b1;
                ctrl.branch   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign reg_read  = ctrl.reg_read;
    assign reg_write = ctrl.reg_write;
    assign reg_dst   = ctrl.reg_dst;
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;
    assign branch    = ctrl.branch;

    mips_alu u_alu (
        .opcode     (opcode),
        .funct      (funct),
        .shamt      (shamt),
        .immediate  (immediate),
        .rs_content (rs_content),
        .rt_content (rt_content),
        .result     (alu_result)
    );

    assign branch_taken = ctrl.branch && (alu_result == 32'd0);

    // Jumps outrank register jumps, which outrank taken branches
    always_comb begin
        pc_next = pc_reg + 32'd1;
        if (opcode == OP_J) begin
            pc_next = {6'b0, address};
        end else if (is_jr) begin
            pc_next = rs_content;
        end else if (branch_taken) begin
            pc_next = pc_reg + 32'd1 + {{16{immediate[15]}}, immediate};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Bench for mips_decode_execute: directed cases plus randomized instructions
// checked against an instruction-level reference model.
module tb_mips_decode_execute;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] address;
    logic        reg_read, reg_write, reg_dst, mem_read, mem_write, branch;
    logic [31:0] alu_result;
    logic        branch_taken;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] model_pc;

    logic [5:0] obs_ctrl;
    assign obs_ctrl = {reg_read, reg_write, reg_dst, mem_read, mem_write, branch};

    mips_decode_execute dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .rs_content   (rs_content),
        .rt_content   (rt_content),
        .pc           (pc),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .immediate    (immediate),
        .address      (address),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .branch       (branch),
        .alu_result   (alu_result),
        .branch_taken (branch_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        int sh = int'(ins[10:6]);
        int simm = $signed(ins[15:0]);
        logic [31:0] imm_s = simm;
        logic [31:0] imm_z = 32'(ins[15:0]);
        logic [31:0] fill;
        if (op == 0) begin
            if (fn == 32 || fn == 33) return a + b;
            if (fn == 34 || fn == 35) return a - b;
            if (fn == 36) return a & b;
            if (fn == 37) return a | b;
            if (fn == 38) return a ^ b;
            if (fn == 39) return ~(a | b);
            if (fn == 42) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            if (fn == 43) return (a < b) ? 32'd1 : 32'd0;
            if (fn == 0)  return b << sh;
            if (fn == 2)  return b >> sh;
            if (fn == 3) begin
                fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (b >> sh) | fill;
            end
            return 32'd0;
        end
        if (op == 8 || op == 9 || op == 35 || op == 43) return a + imm_s;
        if (op == 10) return (int'(a) < simm) ? 32'd1 : 32'd0;
        if (op == 11) return (a < imm_s) ? 32'd1 : 32'd0;
        if (op == 12) return a & imm_z;
        if (op == 13) return a | imm_z;
        if (op == 14) return a ^ imm_z;
        if (op == 15) return imm_z * 32'd65536;
        if (op == 4)  return a - b;
        if (op == 5)  return (a != b) ? 32'd0 : 32'd1;
        return 32'd0;
    endfunction

    // {reg_read, reg_write, reg_dst, mem_read, mem_write, branch}
    function automatic logic [5:0] ref_ctrl(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        if (op == 0) begin
            if (fn == 8) return 6'b100000;
            if (fn inside {0, 2, 3, [32:39], 42, 43}) return 6'b111000;
            return 6'b000000;
        end
        if (op inside {[8:15]}) return 6'b110000;
        if (op == 35) return 6'b110100;
        if (op == 43) return 6'b100010;
        if (op == 4 || op == 5) return 6'b100001;
        return 6'b000000;
    endfunction

    function automatic logic ref_taken(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [5:0] c = ref_ctrl(ins);
        return c[0] && (ref_alu(ins, a, b) == 32'd0);
    endfunction

    function automatic logic [31:0] ref_next_pc(input logic [31:0] ins, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] cur);
        int simm = $signed(ins[15:0]);
        if (ins[31:26] == 6'd2) return {6'b0, ins[25:0]};
        if (ins[31:26] == 6'd0 && ins[5:0] == 6'd8) return a;
        if (ref_taken(ins, a, b)) return cur + 32'd1 + 32'(simm);
        return cur + 32'd1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        instruction = ins;
        rs_content  = a;
        rt_content  = b;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        drive($urandom, $urandom, $urandom);
        tick();
        drive($urandom, $urandom, $urandom);
        tick();
        compared++;
        if (pc !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_pc: got %h expected %h", pc, 32'd0);
        end
        $display("reset held 2 cycles: pc=%h", pc);
        reset = 1'b0;
        drive(32'h0000_0000, 32'd0, 32'd0);
        tick();
        compared++;
        if (pc !== 32'd1) begin
            mismatched++;
            $display("FAIL reset_release_pc: got %h expected %h", pc, 32'd1);
        end
        $display("nop after reset: pc=%h", pc);
        model_pc = 32'd1;
    endtask

    task automatic test_rtype;
        logic [31:0] ins;
        drive(32'h0022_1820, 32'd5, 32'd7);
        compared++;
        if (alu_result !== 32'd12 || reg_write !== 1'b1 || reg_dst !== 1'b1) begin
            mismatched++;
            $display("FAIL add: got res=%h rw=%b rd=%b expected res=0000000c rw=1 rd=1",
                     alu_result, reg_write, reg_dst);
        end
        tick();
        compared++;
        if (pc !== model_pc + 32'd1) begin
            mismatched++;
            $display("FAIL add_pc: got %h expected %h", pc, model_pc + 32'd1);
        end
        $display("add: res=%h pc=%h", alu_result, pc);
        model_pc = model_pc + 32'd1;

        ins = {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03};
        drive(ins, 32'd0, 32'h8000_0000);
        compared++;
        if (alu_result !== 32'hF800_0000) begin
            mismatched++;
            $display("FAIL sra: got %h expected %h", alu_result, 32'hF800_0000);
        end
        $display("sra: res=%h", alu_result);
        tick();
        model_pc = model_pc + 32'd1;

        ins = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A};
        drive(ins, 32'hFFFF_FFFF, 32'd1);
        compared++;
        if (alu_result !== 32'd1) begin
            mismatched++;
            $display("FAIL slt: got %h expected %h", alu_result, 32'd1);
        end
        $display("slt -1<1: res=%h", alu_result);
        tick();
        model_pc = model_pc + 32'd1;

        ins = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B};
        drive(ins, 32'hFFFF_FFFF, 32'd1);
        compared++;
        if (alu_result !== 32'd0) begin
            mismatched++;
            $display("FAIL sltu: got %h expected %h", alu_result, 32'd0);
        end
        $display("sltu -1<1: res=%h", alu_result);
        tick();
        model_pc = model_pc + 32'd1;
    endtask

    task automatic test_branch;
        logic [31:0] ins;
        drive({6'h02, 26'd10}, 32'd0, 32'd0);
        tick();
        ins = {6'h04, 5'd1, 5'd2, 16'hFFFD};
        drive(ins, 32'd9, 32'd9);
        compared++;
        if (branch_taken !== 1'b1 || branch !== 1'b1) begin
            mismatched++;
            $display("FAIL beq_taken: got taken=%b branch=%b expected 1 1", branch_taken, branch);
        end
        tick();
        compared++;
        if (pc !== 32'd8) begin
            mismatched++;
            $display("FAIL beq_back_pc: got %h expected %h", pc, 32'd8);
        end
        $display("beq taken at 10: pc=%h", pc);

        drive({6'h02, 26'd10}, 32'd0, 32'd0);
        tick();
        drive(ins, 32'd9, 32'd3);
        tick();
        compared++;
        if (pc !== 32'd11) begin
            mismatched++;
            $display("FAIL beq_not_taken_pc: got %h expected %h", pc, 32'd11);
        end
        $display("beq not taken at 10: pc=%h", pc);

        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        drive({6'h05, 5'd1, 5'd2, 16'd4}, 32'd1, 32'd2);
        tick();
        compared++;
        if (pc !== 32'd5) begin
            mismatched++;
            $display("FAIL bne_pc: got %h expected %h", pc, 32'd5);
        end
        $display("bne taken at 0: pc=%h", pc);
        model_pc = 32'd5;
    endtask

    task automatic test_jump;
        drive({6'h02, 26'h40}, 32'd0, 32'd0);
        compared++;
        if (obs_ctrl !== 6'b000000) begin
            mismatched++;
            $display("FAIL j_ctrl: got %b expected %b", obs_ctrl, 6'b000000);
        end
        tick();
        compared++;
        if (pc !== 32'h40) begin
            mismatched++;
            $display("FAIL j_pc: got %h expected %h", pc, 32'h40);
        end
        $display("j 0x40: pc=%h", pc);

        drive({6'h00, 5'd31, 15'd0, 6'h08}, 32'h123, 32'd0);
        compared++;
        if (reg_write !== 1'b0 || reg_read !== 1'b1) begin
            mismatched++;
            $display("FAIL jr_ctrl: got rw=%b rr=%b expected rw=0 rr=1", reg_write, reg_read);
        end
        tick();
        compared++;
        if (pc !== 32'h123) begin
            mismatched++;
            $display("FAIL jr_pc: got %h expected %h", pc, 32'h123);
        end
        $display("jr $31: pc=%h", pc);

        drive({6'h00, 5'd31, 15'd0, 6'h08}, 32'hFFFF_FFFF, 32'd0);
        tick();
        drive(32'd0, 32'd0, 32'd0);
        tick();
        compared++;
        if (pc !== 32'd0) begin
            mismatched++;
            $display("FAIL pc_wrap: got %h expected %h", pc, 32'd0);
        end
        $display("pc wrap: pc=%h", pc);
        model_pc = 32'd0;
    endtask

    task automatic test_memory_and_unknown;
        drive({6'h23, 5'd1, 5'd2, 16'hFFFC}, 32'h100, 32'd0);
        compared++;
        if (alu_result !== 32'hFC || mem_read !== 1'b1 || reg_write !== 1'b1) begin
            mismatched++;
            $display("FAIL lw: got res=%h mr=%b rw=%b expected res=000000fc mr=1 rw=1",
                     alu_result, mem_read, reg_write);
        end
        $display("lw: res=%h ctrl=%b", alu_result, obs_ctrl);
        tick();
        drive({6'h2B, 5'd1, 5'd2, 16'h0008}, 32'h200, 32'd5);
        compared++;
        if (mem_write !== 1'b1 || reg_write !== 1'b0 || alu_result !== 32'h208) begin
            mismatched++;
            $display("FAIL sw: got mw=%b rw=%b res=%h expected mw=1 rw=0 res=00000208",
                     mem_write, reg_write, alu_result);
        end
        $display("sw: res=%h ctrl=%b", alu_result, obs_ctrl);
        tick();
        drive({6'h3F, 26'h3FF_FFFF}, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        compared++;
        if (obs_ctrl !== 6'b000000 || alu_result !== 32'd0) begin
            mismatched++;
            $display("FAIL unknown_op: got ctrl=%b res=%h expected ctrl=000000 res=00000000",
                     obs_ctrl, alu_result);
        end
        tick();
        compared++;
        if (pc !== 32'd3) begin
            mismatched++;
            $display("FAIL unknown_op_pc: got %h expected %h", pc, 32'd3);
        end
        $display("opcode 0x3f: ctrl=%b pc=%h", obs_ctrl, pc);
        model_pc = 32'd3;
    endtask

    task automatic test_reset_midprogram;
        drive({6'h02, 26'h1234}, 32'd0, 32'd0);
        tick();
        reset = 1'b1;
        drive({6'h02, 26'h5555}, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        compared++;
        if (pc !== 32'd0) begin
            mismatched++;
            $display("FAIL mid_reset_pc: got %h expected %h", pc, 32'd0);
        end
        $display("reset over jump: pc=%h", pc);
        model_pc = 32'd0;
    endtask

    task automatic test_random;
        logic [5:0] ops [15] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
        logic [31:0] ins, a, b, e_alu, e_pc;
        logic [5:0]  e_ctrl;
        logic        e_taken;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(14)];
            if ($urandom_range(9) == 0) ins[31:26] = 6'($urandom);
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(15)];
            a = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            e_alu   = ref_alu(ins, a, b);
            e_ctrl  = ref_ctrl(ins);
            e_taken = ref_taken(ins, a, b);
            e_pc    = ref_next_pc(ins, a, b, model_pc);
            drive(ins, a, b);
            compared++;
            if (alu_result !== e_alu || obs_ctrl !== e_ctrl || branch_taken !== e_taken) begin
                mismatched++;
                $display("FAIL rand_exec[%0d] ins=%h: got res=%h ctrl=%b tk=%b expected res=%h ctrl=%b tk=%b",
                         n, ins, alu_result, obs_ctrl, branch_taken, e_alu, e_ctrl, e_taken);
            end
            compared++;
            if ({opcode, rs, rt, rd, shamt, funct} !== ins || immediate !== ins[15:0] ||
                address !== ins[25:0]) begin
                mismatched++;
                $display("FAIL rand_fields[%0d]: got %h expected %h", n,
                         {opcode, rs, rt, rd, shamt, funct}, ins);
            end
            tick();
            compared++;
            if (pc !== e_pc) begin
                mismatched++;
                $display("FAIL rand_pc[%0d] ins=%h: got %h expected %h", n, ins, pc, e_pc);
            end
            $display("rand %0d: ins=%h res=%h ctrl=%b pc=%h", n, ins, alu_result, obs_ctrl, pc);
            model_pc = e_pc;
        end
    endtask

    initial begin
        reset       = 1'b1;
        instruction = '0;
        rs_content  = '0;
        rt_content  = '0;
        model_pc    = '0;
        test_reset();
        test_rtype();
        test_branch();
        test_jump();
        test_memory_and_unknown();
        test_reset_midprogram();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
